spi_cfg_master: RTL and testbench
=================================

// Module: spi_cfg_master
// PURPOSE
//   On-chip SPI write master that configures the SPI register peripheral (regs 0x00-0x04: en_out_uo,
//   en_out_uio, en_pwm_uo, en_pwm_uio, pwm_duty_cycle). Queues write requests in a small FIFO.
//   Each request becomes a 16-bit frame {1'b1, addr[6:0], data[7:0]}, sent MSB first, SPI mode 0.
//   After each frame it issues one commit SCLK pulse with NCS high, which the peripheral needs to latch data.
// PARAMETERS
//   CLK_DIV     4  clk cycles per SCLK half-period; legal range >= 1
//   FIFO_DEPTH  4  request FIFO entries; power of 2, >= 2
//   GAP_CYCLES  2  clk cycles of idle (NCS=1, SCLK=0) after commit pulse before next frame; >= 1
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   synchronous, active-low reset
//   req_valid   in   1   write request valid
//   req_ready   out  1   FIFO can accept; = !fifo_full (combinational from level)
//   req_addr    in   7   target register address
//   req_data    in   8   register write data
//   addr_err    out  1   1-cycle pulse: accepted handshake with req_addr > 7'h04, request dropped
//   fifo_level  out  $clog2(FIFO_DEPTH)+1  entries queued (excludes frame in flight)
//   busy        out  1   1 whenever state != IDLE
//   frame_done  out  1   1-cycle pulse at end of commit pulse (SCLK falling edge with NCS=1)
//   ncs         out  1   SPI chip select, active low
//   sclk        out  1   SPI clock, idles low
//   copi        out  1   SPI data out, changes only while sclk low
// BEHAVIOUR
//   Reset (rst_n=0 at posedge clk): ncs=1, sclk=0, copi=0, busy=0, frame_done=0, addr_err=0.
//     fifo_level=0, FIFO pointers cleared, state=IDLE. req_ready=0 while rst_n=0.
//   Reset mid-frame: the frame is abandoned on the next edge. No commit pulse, no frame_done.
//     All queued requests are discarded.
//   Accept: push when req_valid && req_ready. Valid addresses (<= 0x04) are enqueued.
//     Invalid addresses pulse addr_err on the next cycle and are not enqueued.
//   A push and a pop in the same cycle are legal: level is unchanged. There is no bypass:
//     a request pushed in cycle T is popped no earlier than T+1.
//   All SPI outputs are registered. Divider counter div_cnt runs 0..CLK_DIV-1; a phase ends at CLK_DIV-1.
//   FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> COMMIT -> GAP -> IDLE.
//     IDLE:   if FIFO non-empty: pop the entry, load shreg={1,addr,data}.
//             Next edge: ncs=0, copi=shreg[15], bit_cnt=0 -> SETUP.
//     SETUP:  CLK_DIV cycles, sclk=0 (COPI setup time) -> SHIFT.
//     SHIFT:  sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
//             On each high->low transition: bit_cnt++, and copi=next bit if bit_cnt<15.
//             After the 16th low phase -> HOLD.
//     HOLD:   ncs=0, sclk=0, copi=0 for CLK_DIV cycles, then ncs=1 -> COMMIT.
//     COMMIT: ncs=1, sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
//             frame_done pulses in the cycle sclk returns to 0 -> GAP.
//     GAP:    GAP_CYCLES idle cycles -> IDLE.
//   Timing per frame: ncs low exactly 34*CLK_DIV cycles; 16 SCLK rising edges while ncs=0;
//     commit phase 2*CLK_DIV cycles; SCLK period 2*CLK_DIV.
//   Back-to-back frames: NCS-high time between frames = 2*CLK_DIV + GAP_CYCLES + 1 cycles.
//   FIFO full: req_ready=0; requests are held by the requester, never lost. Pointers wrap mod FIFO_DEPTH.
//   fifo_level decrements in the cycle the pop is registered (the IDLE-exit edge).
//   FIFO contents are never reordered. Frames are emitted in acceptance order.
// TESTING
//   1 Single write addr=0x00, data=0xA5, CLK_DIV=4 -> COPI sampled at 16 SCLK rises = 16'h80A5.
//     ncs low 136 cycles; one commit pulse with ncs=1; frame_done pulses once.
//   2 Write addr=0x04, data=0x80; SPI model behind master -> pwm_duty_cycle=0x80 after the commit pulse.
//     Other model registers stay 0.
//   3 6 requests with req_valid held high from idle, FIFO_DEPTH=4 -> req_ready drops once level=4.
//     All 6 frames are sent in order; frame_done count=6; NCS gap between frames = 2*CLK_DIV+GAP_CYCLES+1.
//   4 Request addr=0x05 -> addr_err pulses 1 cycle; fifo_level stays 0; ncs stays 1; no SCLK activity.
//   5 rst_n low for 1 cycle during SHIFT after the 7th SCLK rise, with 2 requests queued ->
//     next edge: ncs=1, sclk=0, copi=0, fifo_level=0, busy=0; no frame_done.
//   6 CLK_DIV=1, GAP_CYCLES=1 -> SCLK period = 2 clk; ncs low 34 cycles.
//     COPI is never observed changing in a cycle where sclk=1.

Source files
------------

// File: rtl/spi_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_cfg_master
// Summary  : Queued SPI mode-0 write master for the config register block.
//            Sends {1,addr,data} frames followed by a commit SCLK pulse.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cfg_master #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [6:0]                  req_addr,
    input  logic [7:0]                  req_data,
    output logic                        addr_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        ncs,
    output logic                        sclk,
    output logic                        copi
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W   = c_PTR_W + 1;
    localparam int c_CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_LVL_W-1:0] c_FULL     = c_LVL_W'(FIFO_DEPTH);
    localparam logic [6:0]         c_ADDR_MAX = 7'h04;
    localparam logic [4:0]         c_LAST_BIT = 5'd15;
    localparam logic [4:0]         c_NUM_BITS = 5'd16;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SETUP  = 3'd1;
    localparam logic [2:0] c_SHIFT  = 3'd2;
    localparam logic [2:0] c_HOLD   = 3'd3;
    localparam logic [2:0] c_COMMIT = 3'd4;
    localparam logic [2:0] c_GAP    = 3'd5;

    logic [14:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_addr_err;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_bit_cnt;
    logic [14:0]        r_shreg;
    logic               r_ncs;
    logic               r_sclk;
    logic               r_copi;
    logic               r_frame_done;

    logic               w_hs;
    logic               w_addr_ok;
    logic               w_push;
    logic               w_pop;
    logic               w_div_end;
    logic               w_gap_end;

    assign req_ready  = rst_n && (r_level != c_FULL);
    assign w_hs       = req_valid && req_ready;
    assign w_addr_ok  = (req_addr <= c_ADDR_MAX);
    assign w_push     = w_hs && w_addr_ok;
    // Pop looks only at the registered level, so a fresh push is never bypassed.
    assign w_pop      = (r_state == c_IDLE) && (r_level != '0);
    assign w_div_end  = (r_cnt == c_DIV_LAST);
    assign w_gap_end  = (r_cnt == c_GAP_LAST);

    assign addr_err   = r_addr_err;
    assign fifo_level = r_level;
    assign busy       = (r_state != c_IDLE);
    assign frame_done = r_frame_done;
    assign ncs        = r_ncs;
    assign sclk       = r_sclk;
    assign copi       = r_copi;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_addr, req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_hs && !w_addr_ok;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_ncs        <= 1'b1;
            r_sclk       <= 1'b0;
            r_copi       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (w_pop) begin
                        // The write flag is the first bit out; the shifter holds the rest.
                        r_shreg   <= r_mem[r_rd_ptr];
                        r_copi    <= 1'b1;
                        r_ncs     <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    if (w_div_end) begin
                        r_cnt   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= c_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_SHIFT: begin
                    if (w_div_end) begin
                        r_cnt <= '0;
                        if (r_sclk) begin
                            r_sclk    <= 1'b0;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt < c_LAST_BIT) begin
                                r_copi  <= r_shreg[14];
                                r_shreg <= {r_shreg[13:0], 1'b0};
                            end
                        end else if (r_bit_cnt == c_NUM_BITS) begin
                            r_copi  <= 1'b0;
                            r_state <= c_HOLD;
                        end else begin
                            r_sclk <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_HOLD: begin
                    if (w_div_end) begin
                        // Commit pulse starts together with NCS release.
                        r_cnt   <= '0;
                        r_ncs   <= 1'b1;
                        r_sclk  <= 1'b1;
                        r_state <= c_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_COMMIT: begin
                    if (w_div_end) begin
                        r_cnt <= '0;
                        if (r_sclk) begin
                            r_sclk       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= c_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_GAP: begin
                    if (w_gap_end) begin
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cfg_master
// Summary  : Self-checking bench for spi_cfg_master (default and fast divider).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cfg_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   = 1'b0;
    logic       a_valid = 1'b0;
    logic [6:0] a_addr  = '0;
    logic [7:0] a_data  = '0;
    logic       a_ready, a_err, a_busy, a_done, a_ncs, a_sclk, a_copi;
    logic [2:0] a_level;
    logic       b_valid = 1'b0;
    logic [6:0] b_addr  = '0;
    logic [7:0] b_data  = '0;
    logic       b_ready, b_err, b_busy, b_done, b_ncs, b_sclk, b_copi;
    logic [2:0] b_level;

    spi_cfg_master #(.CLK_DIV(4), .FIFO_DEPTH(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_addr(a_addr), .req_data(a_data), .addr_err(a_err), .fifo_level(a_level),
        .busy(a_busy), .frame_done(a_done), .ncs(a_ncs), .sclk(a_sclk), .copi(a_copi)
    );

    spi_cfg_master #(.CLK_DIV(1), .FIFO_DEPTH(4), .GAP_CYCLES(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_addr(b_addr), .req_data(b_data), .addr_err(b_err), .fifo_level(b_level),
        .busy(b_busy), .frame_done(b_done), .ncs(b_ncs), .sclk(b_sclk), .copi(b_copi)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI-side observer and register model for the default-divider master
    logic        pa_sclk = 1'b0, pa_ncs = 1'b1, pa_copi = 1'b0;
    logic [15:0] a_rx = '0;
    int          a_bits = 0, a_low = 0, a_last_low = 0, a_last_bits = 0, a_hi = 0;
    int          a_commits = 0, a_done_cnt = 0, a_done_bad = 0, a_copi_bad = 0;
    int          a_rises = 0, a_falls = 0;
    logic [15:0] a_frames [$];
    int          a_gaps [$];
    logic [7:0]  a_model [5] = '{default: 8'h00};

    always @(negedge clk) begin
        pa_sclk <= a_sclk;
        pa_ncs  <= a_ncs;
        pa_copi <= a_copi;
        if (a_sclk && !pa_sclk) begin
            a_rises <= a_rises + 1;
            if (!a_ncs) begin
                a_rx   <= {a_rx[14:0], a_copi};
                a_bits <= a_bits + 1;
            end else begin
                a_commits <= a_commits + 1;
                a_frames.push_back(a_rx);
                if (a_bits == 16 && a_rx[15] && a_rx[14:8] <= 7'h04)
                    a_model[a_rx[10:8]] <= a_rx[7:0];
            end
        end
        if (!a_ncs) begin
            a_low <= pa_ncs ? 1 : a_low + 1;
            if (pa_ncs) begin
                a_gaps.push_back(a_hi);
                a_bits  <= 0;
                a_falls <= a_falls + 1;
            end
        end else begin
            a_hi <= pa_ncs ? a_hi + 1 : 1;
            if (!pa_ncs) begin
                a_last_low  <= a_low;
                a_last_bits <= a_bits;
            end
        end
        if (a_done) begin
            a_done_cnt <= a_done_cnt + 1;
            if (!(pa_sclk && !a_sclk && a_ncs)) a_done_bad <= a_done_bad + 1;
        end
        if (a_sclk && (a_copi !== pa_copi)) a_copi_bad <= a_copi_bad + 1;
    end

    // Observer for the fast master
    logic        pb_sclk = 1'b0, pb_ncs = 1'b1, pb_copi = 1'b0;
    logic [15:0] b_rx = '0;
    int          b_bits = 0, b_low = 0, b_last_low = 0, b_hi = 0, b_since = 0;
    int          b_per_bad = 0, b_copi_bad = 0, b_done_cnt = 0;
    logic [15:0] b_frames [$];
    int          b_gaps [$];

    always @(negedge clk) begin
        pb_sclk <= b_sclk;
        pb_ncs  <= b_ncs;
        pb_copi <= b_copi;
        b_since <= (b_sclk && !pb_sclk) ? 1 : b_since + 1;
        if (b_sclk && !pb_sclk) begin
            if (!b_ncs) begin
                if (b_bits != 0 && b_since != 2) b_per_bad <= b_per_bad + 1;
                b_rx   <= {b_rx[14:0], b_copi};
                b_bits <= b_bits + 1;
            end else begin
                b_frames.push_back(b_rx);
            end
        end
        if (!b_ncs) begin
            b_low <= pb_ncs ? 1 : b_low + 1;
            if (pb_ncs) begin
                b_gaps.push_back(b_hi);
                b_bits <= 0;
            end
        end else begin
            b_hi <= pb_ncs ? b_hi + 1 : 1;
            if (!pb_ncs) b_last_low <= b_low;
        end
        if (b_done) b_done_cnt <= b_done_cnt + 1;
        if (b_sclk && (b_copi !== pb_copi)) b_copi_bad <= b_copi_bad + 1;
    end

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] frame;
        logic        err;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] exp_regs [5] = '{default: 8'h00};

    task automatic send_a(input logic [6:0] addr, input logic [7:0] data);
        int t;
        t = 0;
        @(negedge clk);
        while (!a_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("req_ready before send", a_ready, 1'b1);
        a_valid = 1'b1;
        a_addr  = addr;
        a_data  = data;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget);
        int t;
        t = 0;
        while (a_done !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("frame_done within budget", t < budget, 1'b1);
        t = 0;
        while (a_busy !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("busy clears within budget", t < budget, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int   t, k, nfr, done0, commits0, falls0, rises0, low_seen;
        int   max_lvl, full_seen, ready_bad;
        logic hs;

        vecs[0] = '{7'h00, 8'hA5, 16'h80A5, 1'b0};
        vecs[1] = '{7'h04, 8'h80, 16'h8480, 1'b0};
        vecs[2] = '{7'h05, 8'h11, 16'h0000, 1'b1};
        vecs[3] = '{7'h01, 8'h3C, 16'h813C, 1'b0};
        vecs[4] = '{7'h7F, 8'hFF, 16'h0000, 1'b1};
        vecs[5] = '{7'h02, 8'hFF, 16'h82FF, 1'b0};
        vecs[6] = '{7'h03, 8'h00, 16'h8300, 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ncs", a_ncs, 1'b1);
        check("reset sclk", a_sclk, 1'b0);
        check("reset copi", a_copi, 1'b0);
        check("reset busy", a_busy, 1'b0);
        check("reset level", a_level, 0);
        check("reset req_ready", a_ready, 1'b0);
        check("reset addr_err", a_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", a_ready, 1'b1);

        // Single-request vectors
        for (int i = 0; i < 7; i++) begin
            done0  = a_done_cnt;
            rises0 = a_rises;
            nfr    = a_frames.size();
            send_a(vecs[i].addr, vecs[i].data);
            check($sformatf("v%0d addr_err", i), a_err, vecs[i].err);
            check($sformatf("v%0d level after push", i), a_level, vecs[i].err ? 0 : 1);
            @(negedge clk);
            check($sformatf("v%0d addr_err one cycle", i), a_err, 1'b0);
            if (vecs[i].err) begin
                low_seen = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (a_ncs !== 1'b1) low_seen++;
                end
                check($sformatf("v%0d ncs stays high", i), low_seen, 0);
                check($sformatf("v%0d no sclk", i), a_rises, rises0);
                check($sformatf("v%0d level stays 0", i), a_level, 0);
                check($sformatf("v%0d no frame_done", i), a_done_cnt, done0);
            end else begin
                check($sformatf("v%0d popped", i), {a_level, a_ncs, a_busy}, {3'd0, 1'b0, 1'b1});
                exp_regs[vecs[i].addr[2:0]] = vecs[i].data;
                wait_idle_a(400);
                check($sformatf("v%0d frame", i),
                      (a_frames.size() > nfr) ? {16'h0, a_frames[nfr]} : 32'hDEAD0000,
                      {16'h0, vecs[i].frame});
                check($sformatf("v%0d ncs low cycles", i), a_last_low, 136);
                check($sformatf("v%0d sclk rises in frame", i), a_last_bits, 16);
                check($sformatf("v%0d frame_done count", i), a_done_cnt, done0 + 1);
                check($sformatf("v%0d model reg", i), a_model[vecs[i].addr[2:0]], vecs[i].data);
            end
        end

        // Burst of 6 with valid held high: FIFO fills, order and gaps preserved
        a_gaps.delete();
        nfr = a_frames.size();
        done0 = a_done_cnt;
        k = 0; t = 0; max_lvl = 0; full_seen = 0; ready_bad = 0;
        a_valid = 1'b1;
        while (k < 6 && t < 3000) begin
            a_addr = 7'(k % 5);
            a_data = 8'(8'h10 + k);
            hs = a_ready;
            if (int'(a_level) > max_lvl) max_lvl = int'(a_level);
            if (!a_ready) full_seen++;
            if ((a_level == 3'd4) == a_ready) ready_bad++;
            @(negedge clk);
            t++;
            if (hs) begin
                exp_regs[k % 5] = 8'(8'h10 + k);
                k++;
            end
        end
        a_valid = 1'b0;
        check("burst all accepted", k, 6);
        check("burst max level", max_lvl, 4);
        check("burst ready dropped", full_seen > 0, 1'b1);
        check("burst ready tracks full", ready_bad, 0);
        t = 0;
        while (a_done_cnt - done0 < 6 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("burst six frame_done", a_done_cnt - done0, 6);
        wait_idle_a(400);
        for (int j = 0; j < 6; j++) begin
            check($sformatf("burst frame %0d", j),
                  (a_frames.size() > nfr + j) ? {16'h0, a_frames[nfr + j]} : 32'hDEAD0000,
                  {16'h0, 1'b1, 7'(j % 5), 8'(8'h10 + j)});
        end
        for (int j = 1; j < 6; j++) begin
            check($sformatf("burst ncs gap %0d", j),
                  (a_gaps.size() > j) ? a_gaps[j] : -1, 2 * 4 + 2 + 1);
        end

        // Reset during SHIFT with two requests queued
        @(negedge clk);
        a_valid = 1'b1; a_addr = 7'h01; a_data = 8'h55;
        @(negedge clk);
        a_addr = 7'h02; a_data = 8'h66;
        @(negedge clk);
        a_addr = 7'h03; a_data = 8'h77;
        @(negedge clk);
        a_valid = 1'b0;
        check("two requests queued", a_level, 2);
        t = 0;
        while (a_bits != 7 && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("reached 7th sclk rise", t < 500, 1'b1);
        done0 = a_done_cnt; commits0 = a_commits; falls0 = a_falls;
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset ncs", a_ncs, 1'b1);
        check("midreset sclk", a_sclk, 1'b0);
        check("midreset copi", a_copi, 1'b0);
        check("midreset level", a_level, 0);
        check("midreset busy", a_busy, 1'b0);
        check("midreset req_ready", a_ready, 1'b0);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("midreset no frame_done", a_done_cnt, done0);
        check("midreset no commit", a_commits, commits0);
        check("midreset queue discarded", a_falls, falls0);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("final model reg %0d", j), a_model[j], exp_regs[j]);
        end
        check("frame_done aligned with commit fall", a_done_bad, 0);
        check("copi stable while sclk high", a_copi_bad, 0);

        // Fast divider: CLK_DIV=1, GAP_CYCLES=1
        @(negedge clk);
        b_valid = 1'b1; b_addr = 7'h02; b_data = 8'hC3;
        @(negedge clk);
        b_addr = 7'h04; b_data = 8'h5A;
        @(negedge clk);
        b_valid = 1'b0;
        t = 0;
        while (b_done_cnt < 2 && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("fast two frame_done", b_done_cnt, 2);
        repeat (5) @(negedge clk);
        check("fast frame 0", (b_frames.size() > 0) ? {16'h0, b_frames[0]} : 32'hDEAD0000, 32'h82C3);
        check("fast frame 1", (b_frames.size() > 1) ? {16'h0, b_frames[1]} : 32'hDEAD0000, 32'h845A);
        check("fast ncs low cycles", b_last_low, 34);
        check("fast sclk period", b_per_bad, 0);
        check("fast copi stable while sclk high", b_copi_bad, 0);
        check("fast ncs gap", (b_gaps.size() > 1) ? b_gaps[1] : -1, 2 * 1 + 1 + 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
